// File: rtl/psram_xfer_arb.sv
// Arbiter sharing one psram_core transfer port between the APB config
// path and the AXI bus path, with recovery gap and done-timeout watchdog.
module psram_xfer_arb #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 64,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cfg_en_i,
   input  logic [7:0]              recy_i,
   input  logic                    cfg_req_i,
   input  logic                    cfg_rdwr_i,
   input  logic [ADDR_WIDTH-1:0]   cfg_addr_i,
   input  logic [7:0]              cfg_wdata_i,
   output logic                    cfg_ack_o,
   output logic                    cfg_err_o,
   output logic [7:0]              cfg_rdata_o,
   input  logic                    bus_req_i,
   input  logic                    bus_rdwr_i,
   input  logic [ADDR_WIDTH-1:0]   bus_addr_i,
   input  logic [DATA_WIDTH-1:0]   bus_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] bus_mask_i,
   output logic                    bus_ack_o,
   output logic                    bus_err_o,
   output logic [DATA_WIDTH-1:0]   bus_rdata_o,
   input  logic                    xfer_ready_i,
   input  logic                    xfer_done_i,
   input  logic [DATA_WIDTH-1:0]   xfer_rdata_i,
   output logic                    xfer_valid_o,
   output logic                    xfer_rdwr_o,
   output logic                    xfer_cflg_o,
   output logic [ADDR_WIDTH-1:0]   xfer_addr_o,
   output logic [DATA_WIDTH-1:0]   xfer_wdata_o,
   output logic [DATA_WIDTH/8-1:0] xfer_mask_o,
   output logic                    busy_o
);

   localparam int MW = DATA_WIDTH / 8;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ACK,
      S_RECOVER
   } state_t;

   state_t          state;
   logic [SW-1:0]   starve_cnt;
   logic [TW-1:0]   tmo_cnt;
   logic [7:0]      recy_cnt;
   logic            own_bus;
   logic            grant;
   logic            pick_bus;

   assign grant    = cfg_en_i & xfer_ready_i & (cfg_req_i | bus_req_i);
   assign pick_bus = bus_req_i & (~cfg_req_i | (starve_cnt == STARVE_MAX));
   assign busy_o   = (state != S_IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         starve_cnt   <= '0;
         tmo_cnt      <= '0;
         recy_cnt     <= '0;
         own_bus      <= 1'b0;
         cfg_ack_o    <= 1'b0;
         cfg_err_o    <= 1'b0;
         cfg_rdata_o  <= '0;
         bus_ack_o    <= 1'b0;
         bus_err_o    <= 1'b0;
         bus_rdata_o  <= '0;
         xfer_valid_o <= 1'b0;
         xfer_rdwr_o  <= 1'b0;
         xfer_cflg_o  <= 1'b0;
         xfer_addr_o  <= '0;
         xfer_wdata_o <= '0;
         xfer_mask_o  <= '0;
      end else begin
         xfer_valid_o <= 1'b0;
         cfg_ack_o    <= 1'b0;
         cfg_err_o    <= 1'b0;
         bus_ack_o    <= 1'b0;
         bus_err_o    <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (grant) begin
                  state        <= S_ISSUE;
                  xfer_valid_o <= 1'b1;
                  own_bus      <= pick_bus;
                  xfer_cflg_o  <= ~pick_bus;
                  if (pick_bus) begin
                     xfer_rdwr_o  <= bus_rdwr_i;
                     xfer_addr_o  <= bus_addr_i;
                     xfer_wdata_o <= bus_wdata_i;
                     xfer_mask_o  <= bus_mask_i;
                     starve_cnt   <= '0;
                  end else begin
                     xfer_rdwr_o  <= cfg_rdwr_i;
                     xfer_addr_o  <= cfg_addr_i;
                     xfer_wdata_o <= DATA_WIDTH'(cfg_wdata_i);
                     xfer_mask_o  <= MW'(1);
                     // only a waiting bus counts toward starvation
                     if (bus_req_i && starve_cnt != STARVE_MAX)
                        starve_cnt <= starve_cnt + SW'(1);
                  end
               end
            end
            S_ISSUE: begin
               tmo_cnt <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               tmo_cnt <= tmo_cnt + TW'(1);
               if (xfer_done_i) begin
                  state <= S_ACK;
                  if (own_bus) begin
                     bus_rdata_o <= xfer_rdata_i;
                     bus_ack_o   <= 1'b1;
                  end else begin
                     cfg_rdata_o <= xfer_rdata_i[7:0];
                     cfg_ack_o   <= 1'b1;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  state <= S_ACK;
                  if (own_bus) begin
                     bus_ack_o <= 1'b1;
                     bus_err_o <= 1'b1;
                  end else begin
                     cfg_ack_o <= 1'b1;
                     cfg_err_o <= 1'b1;
                  end
               end
            end
            S_ACK: begin
               recy_cnt <= recy_i;
               state    <= (recy_i == 8'd0) ? S_IDLE : S_RECOVER;
            end
            S_RECOVER: begin
               recy_cnt <= recy_cnt - 8'd1;
               if (recy_cnt <= 8'd1)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psram_xfer_arb.sv
// Bench for psram_xfer_arb: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration/timing model.
module tb_psram_xfer_arb;

   localparam int AW  = 32;
   localparam int DW  = 64;
   localparam int MW  = 8;
   localparam int SL  = 4;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          cfg_en_i;
   logic [7:0]    recy_i;
   logic          cfg_req_i;
   logic          cfg_rdwr_i;
   logic [AW-1:0] cfg_addr_i;
   logic [7:0]    cfg_wdata_i;
   logic          cfg_ack_o;
   logic          cfg_err_o;
   logic [7:0]    cfg_rdata_o;
   logic          bus_req_i;
   logic          bus_rdwr_i;
   logic [AW-1:0] bus_addr_i;
   logic [DW-1:0] bus_wdata_i;
   logic [MW-1:0] bus_mask_i;
   logic          bus_ack_o;
   logic          bus_err_o;
   logic [DW-1:0] bus_rdata_o;
   logic          xfer_ready_i;
   logic          xfer_done_i;
   logic [DW-1:0] xfer_rdata_i;
   logic          xfer_valid_o;
   logic          xfer_rdwr_o;
   logic          xfer_cflg_o;
   logic [AW-1:0] xfer_addr_o;
   logic [DW-1:0] xfer_wdata_o;
   logic [MW-1:0] xfer_mask_o;
   logic          busy_o;

   psram_xfer_arb #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .STARVE_LIMIT(SL),
      .TIMEOUT(TMO)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .cfg_en_i(cfg_en_i),
      .recy_i(recy_i),
      .cfg_req_i(cfg_req_i),
      .cfg_rdwr_i(cfg_rdwr_i),
      .cfg_addr_i(cfg_addr_i),
      .cfg_wdata_i(cfg_wdata_i),
      .cfg_ack_o(cfg_ack_o),
      .cfg_err_o(cfg_err_o),
      .cfg_rdata_o(cfg_rdata_o),
      .bus_req_i(bus_req_i),
      .bus_rdwr_i(bus_rdwr_i),
      .bus_addr_i(bus_addr_i),
      .bus_wdata_i(bus_wdata_i),
      .bus_mask_i(bus_mask_i),
      .bus_ack_o(bus_ack_o),
      .bus_err_o(bus_err_o),
      .bus_rdata_o(bus_rdata_o),
      .xfer_ready_i(xfer_ready_i),
      .xfer_done_i(xfer_done_i),
      .xfer_rdata_i(xfer_rdata_i),
      .xfer_valid_o(xfer_valid_o),
      .xfer_rdwr_o(xfer_rdwr_o),
      .xfer_cflg_o(xfer_cflg_o),
      .xfer_addr_o(xfer_addr_o),
      .xfer_wdata_o(xfer_wdata_o),
      .xfer_mask_o(xfer_mask_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          total = 0;
   int          bad   = 0;
   bit          pend_c, pend_b, chaos;
   int          starve;
   logic [7:0]  m_crd;
   logic [63:0] m_brd;
   int          last_ack, last_recy;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic raise_cfg();
      pend_c      = 1'b1;
      cfg_req_i   = 1'b1;
      cfg_rdwr_i  = 1'($urandom);
      cfg_addr_i  = $urandom;
      cfg_wdata_i = 8'($urandom);
   endtask

   task automatic raise_bus();
      pend_b      = 1'b1;
      bus_req_i   = 1'b1;
      bus_rdwr_i  = 1'($urandom);
      bus_addr_i  = $urandom;
      bus_wdata_i = {$urandom, $urandom};
      bus_mask_i  = 8'($urandom);
   endtask

   // One whole transaction: predicted winner, issue timing, completion.
   task automatic serve(input int dly, input int exp_v,
                        input logic [7:0] recy_v, input logic [63:0] crd,
                        output bit got_cfg);
      bit          wb, err;
      int          v, a, vc;
      logic        erw;
      logic [31:0] eaddr;
      logic [63:0] ew;
      logic [7:0]  em;
      wb = pend_b && (!pend_c || starve == SL);
      if (wb) starve = 0;
      else if (pend_b && starve < SL) starve++;
      if (wb) begin
         erw = bus_rdwr_i; eaddr = bus_addr_i;
         ew  = bus_wdata_i; em = bus_mask_i;
      end else begin
         erw = cfg_rdwr_i; eaddr = cfg_addr_i;
         ew  = {56'd0, cfg_wdata_i}; em = 8'h01;
      end
      xfer_rdata_i = crd;
      recy_i = recy_v;
      got_cfg = 1'b0;
      v = -1;
      for (int i = 0; i < 300 && v < 0; i++) begin
         tick();
         xfer_done_i = 1'b0;
         if (xfer_valid_o) v = cyc;
      end
      if (v < 0) begin
         chk("valid_seen", 64'd0, 64'd1);
         return;
      end
      got_cfg = xfer_cflg_o;
      if (exp_v >= 0) chk("valid_cycle", 64'(v), 64'(exp_v));
      chk("cflg", 64'(xfer_cflg_o), 64'(!wb));
      chk("rdwr", 64'(xfer_rdwr_o), 64'(erw));
      chk("addr", 64'(xfer_addr_o), 64'(eaddr));
      chk("wdata", xfer_wdata_o, ew);
      chk("mask", 64'(xfer_mask_o), 64'(em));
      chk("busy", 64'(busy_o), 64'd1);
      if (chaos && $urandom_range(3) == 0) cfg_en_i = 1'b0;
      if (chaos && $urandom_range(3) == 0) begin
         if (wb) bus_req_i = 1'b0; else cfg_req_i = 1'b0;
      end
      a = -1; vc = 0;
      for (int i = 0; i < 40 && a < 0; i++) begin
         tick();
         xfer_done_i = (dly > 0) && (cyc == v + dly);
         if (xfer_valid_o) vc++;
         if (cfg_ack_o || bus_ack_o) a = cyc;
      end
      xfer_done_i = 1'b0;
      cfg_en_i = 1'b1;
      if (wb) begin bus_req_i = 1'b0; pend_b = 1'b0; end
      else begin cfg_req_i = 1'b0; pend_c = 1'b0; end
      if (a < 0) begin
         chk("ack_seen", 64'd0, 64'd1);
         return;
      end
      err = !(dly >= 1 && dly <= TMO);
      if (!err) begin
         if (wb) m_brd = crd; else m_crd = crd[7:0];
      end
      chk("ack_cycle", 64'(a), 64'(err ? v + TMO + 1 : v + dly + 1));
      chk("ack_owner", 64'({cfg_ack_o, bus_ack_o}),
          64'(wb ? 2'b01 : 2'b10));
      chk("ack_err", 64'(wb ? bus_err_o : cfg_err_o), 64'(err));
      chk("cfg_rdata", 64'(cfg_rdata_o), 64'(m_crd));
      chk("bus_rdata", bus_rdata_o, m_brd);
      chk("addr_hold", 64'(xfer_addr_o), 64'(eaddr));
      chk("extra_valid", 64'(vc), 64'd0);
      last_ack  = a;
      last_recy = int'(recy_v);
   endtask

   // Cycle after ack: ack must have dropped; refill requests.
   task automatic after_ack(input bit keep_c, input bit keep_b,
                            input bit rnd, input bit force_one);
      tick();
      chk("ack_pulse", 64'({cfg_ack_o, bus_ack_o}), 64'd0);
      xfer_done_i = 1'($urandom);
      if (!pend_c && (keep_c || (rnd && $urandom_range(1) == 1)))
         raise_cfg();
      if (!pend_b && (keep_b || (rnd && $urandom_range(1) == 1)))
         raise_bus();
      if (force_one && !pend_c && !pend_b) begin
         if ($urandom_range(1) == 1) raise_cfg(); else raise_bus();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit       gc;
      int       r, cnt, v;
      bit       order [6];
      rst_i = 1'b1; cfg_en_i = 1'b1; recy_i = 8'd0;
      cfg_req_i = 1'b0; cfg_rdwr_i = 1'b0; cfg_addr_i = '0;
      cfg_wdata_i = '0; bus_req_i = 1'b0; bus_rdwr_i = 1'b0;
      bus_addr_i = '0; bus_wdata_i = '0; bus_mask_i = '0;
      xfer_ready_i = 1'b1; xfer_done_i = 1'b0; xfer_rdata_i = '0;
      pend_c = 0; pend_b = 0; chaos = 0; starve = 0;
      m_crd = '0; m_brd = '0;
      order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tick(); tick();
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_valid", 64'(xfer_valid_o), 64'd0);
      chk("rst_acks", 64'({cfg_ack_o, bus_ack_o}), 64'd0);
      chk("rst_cfg_rdata", 64'(cfg_rdata_o), 64'd0);
      chk("rst_bus_rdata", bus_rdata_o, 64'd0);
      chk("rst_xfer", 64'({xfer_addr_o, xfer_mask_o}), 64'd0);
      rst_i = 1'b0;

      // cfg write, no recovery, done 5 cycles after valid
      tick();
      raise_cfg();
      cfg_rdwr_i = 1'b0; cfg_addr_i = 32'h1234; cfg_wdata_i = 8'hA5;
      r = cyc;
      serve(5, r + 1, 8'd0, 64'h0, gc);
      chk("t1_mask", 64'(xfer_mask_o), 64'h01);
      after_ack(0, 0, 0, 0);

      // bus read returning a fixed word
      raise_bus();
      bus_rdwr_i = 1'b1; bus_mask_i = 8'hFF;
      serve(3, last_ack + 2, 8'd0, 64'hDEADBEEF_01234567, gc);
      after_ack(0, 0, 0, 0);
      tick(); tick();
      chk("t2_rdata_held", bus_rdata_o, 64'hDEADBEEF_01234567);

      // both requesters held: starvation ordering
      raise_cfg(); raise_bus();
      r = cyc;
      for (int i = 0; i < 6; i++) begin
         serve(2, (i == 0) ? r + 1 : last_ack + 2, 8'd0,
               {$urandom, $urandom}, gc);
         chk("starve_order", 64'(gc), 64'(order[i]));
         after_ack(i < 5, 1, 0, 0);
      end
      serve(2, last_ack + 2, 8'd0, {$urandom, $urandom}, gc);
      after_ack(0, 0, 0, 0);

      // recovery gap of 3
      tick();
      raise_cfg();
      r = cyc;
      serve(2, r + 1, 8'd3, {$urandom, $urandom}, gc);
      after_ack(1, 0, 0, 0);
      serve(2, last_ack + 5, 8'd0, {$urandom, $urandom}, gc);

      // watchdog timeout, then edges of the done window
      after_ack(1, 0, 0, 0);
      serve(0, last_ack + 2, 8'd0, {$urandom, $urandom}, gc);
      after_ack(1, 0, 0, 0);
      serve(4, last_ack + 2, 8'd0, {$urandom, $urandom}, gc);
      after_ack(0, 1, 0, 0);
      serve(TMO, last_ack + 2, 8'd0, {$urandom, $urandom}, gc);
      after_ack(0, 1, 0, 0);
      serve(TMO + 1, last_ack + 2, 8'd0, {$urandom, $urandom}, gc);
      after_ack(0, 0, 0, 0);

      // disabled controller / busy core block new grants
      cfg_en_i = 1'b0;
      raise_cfg();
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         xfer_done_i = 1'b0;
         if (xfer_valid_o || busy_o) cnt++;
      end
      chk("en_block", 64'(cnt), 64'd0);
      cfg_en_i = 1'b1; xfer_ready_i = 1'b0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (xfer_valid_o || busy_o) cnt++;
      end
      chk("ready_block", 64'(cnt), 64'd0);
      xfer_ready_i = 1'b1;
      r = cyc;
      serve(3, r + 1, 8'd0, {$urandom, $urandom}, gc);
      after_ack(0, 0, 0, 0);

      // reset while waiting for done
      raise_cfg();
      v = -1;
      for (int i = 0; i < 10 && v < 0; i++) begin
         tick();
         xfer_done_i = 1'b0;
         if (xfer_valid_o) v = cyc;
      end
      chk("rst_t_valid", 64'(v >= 0), 64'd1);
      tick(); tick();
      rst_i = 1'b1; cfg_req_i = 1'b0; pend_c = 1'b0;
      tick();
      chk("rst_t_busy", 64'(busy_o), 64'd0);
      chk("rst_t_rdata", 64'(cfg_rdata_o), 64'd0);
      rst_i = 1'b0; starve = 0; m_crd = '0; m_brd = '0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         xfer_done_i = (i == 3);
         if (cfg_ack_o || bus_ack_o || xfer_valid_o) cnt++;
      end
      xfer_done_i = 1'b0;
      chk("rst_t_quiet", 64'(cnt), 64'd0);

      // randomized traffic
      chaos = 1'b1;
      raise_bus();
      r = cyc;
      serve(3, r + 1, 8'd0, {$urandom, $urandom}, gc);
      for (int i = 0; i < 60; i++) begin
         int d;
         after_ack(0, 0, 1, 1);
         case ($urandom_range(9))
            0:       d = 0;
            1:       d = TMO;
            default: d = $urandom_range(1, 8);
         endcase
         serve(d, last_ack + last_recy + 2, 8'($urandom_range(4)),
               {$urandom, $urandom}, gc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
